// File: rtl/sfo_sweep_controller.sv
// Captures one FFT magnitude frame, replays it to the SFO correlator once per
// swept hypothesis, and reports the hypothesis with the highest correlator score.
module sfo_sweep_controller #(
    parameter int FFT_LEN_LOG2   = 9,
    parameter int POWER_WIDTH    = 16,
    parameter int SFO_INT_WIDTH  = 9,
    parameter int SFO_FRAC_WIDTH = 16,
    parameter int CORR_WIDTH     = 26,
    parameter int NUM_HYP_LOG2   = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [POWER_WIDTH-1:0]                  fft_mag_in,
    input  logic                                    fft_mag_valid,
    input  logic                                    fft_mag_last,
    output logic                                    fft_mag_ready,
    input  logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] sweep_start,
    input  logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] sweep_step,
    input  logic [NUM_HYP_LOG2-1:0]                 sweep_num_hyp,
    output logic [SFO_INT_WIDTH-1:0]                sfo_int_part,
    output logic [SFO_FRAC_WIDTH-1:0]               sfo_frac_part,
    output logic                                    correlation_reset,
    output logic                                    correlation_update,
    output logic [POWER_WIDTH-1:0]                  fft_mag_out,
    input  logic [CORR_WIDTH-1:0]                   correlation_in,
    input  logic                                    correlation_in_valid,
    output logic [NUM_HYP_LOG2-1:0]                 best_index,
    output logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] best_sfo,
    output logic [CORR_WIDTH-1:0]                   best_corr,
    output logic                                    result_valid,
    output logic                                    busy,
    output logic                                    timeout_err,
    output logic                                    frame_err
);

    localparam int FFT_LEN = 2 ** FFT_LEN_LOG2;
    localparam int SFO_W   = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FFT_LEN_LOG2-1:0] LAST_BIN  = FFT_LEN_LOG2'(FFT_LEN - 1);
    localparam logic [FFT_LEN_LOG2-1:0] ADDR_ONE  = FFT_LEN_LOG2'(1);
    localparam logic [WAIT_W-1:0]       WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0]       WAIT_ONE  = WAIT_W'(1);
    localparam logic [NUM_HYP_LOG2-1:0] HYP_ONE   = NUM_HYP_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RST  = 3'd2,
        S_PLAY = 3'd3,
        S_WAIT = 3'd4,
        S_CMP  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic [FFT_LEN_LOG2-1:0]   wr_addr_q, wr_addr_d;
    logic [FFT_LEN_LOG2-1:0]   play_cnt_q, play_cnt_d;
    logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic [NUM_HYP_LOG2-1:0]   k_q, k_d;
    logic [NUM_HYP_LOG2-1:0]   num_hyp_q, num_hyp_d;
    logic [SFO_W-1:0]          hyp_q, hyp_d;
    logic [SFO_W-1:0]          step_q, step_d;
    logic [CORR_WIDTH-1:0]     score_q, score_d;
    logic                      score_vld_q, score_vld_d;
    logic [NUM_HYP_LOG2-1:0]   best_index_q, best_index_d;
    logic [SFO_W-1:0]          best_sfo_q, best_sfo_d;
    logic [CORR_WIDTH-1:0]     best_corr_q, best_corr_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      frame_err_q, frame_err_d;
    logic                      result_valid_q, corr_reset_q, corr_update_q;
    logic                      ready_q, busy_q;
    logic [POWER_WIDTH-1:0]    mag_out_q;
    logic                      wr_en_s;
    logic [FFT_LEN_LOG2-1:0]   wr_idx_s;
    logic [FFT_LEN_LOG2-1:0]   rd_idx_s;
    logic [POWER_WIDTH-1:0]    mem_q [FFT_LEN];

    // Next-state and datapath control for the load / replay / score sequence.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        play_cnt_d    = play_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        k_d           = k_q;
        num_hyp_d     = num_hyp_q;
        hyp_d         = hyp_q;
        step_d        = step_q;
        score_d       = score_q;
        score_vld_d   = score_vld_q;
        best_index_d  = best_index_q;
        best_sfo_d    = best_sfo_q;
        best_corr_d   = best_corr_q;
        timeout_err_d = timeout_err_q;
        frame_err_d   = 1'b0;
        wr_en_s       = 1'b0;
        wr_idx_s      = wr_addr_q;
        rd_idx_s      = play_cnt_q + ADDR_ONE;
        case (state_q)
            S_IDLE: begin
                if (fft_mag_valid) begin
                    wr_en_s       = 1'b1;
                    wr_idx_s      = '0;
                    timeout_err_d = 1'b0;
                    best_index_d  = '0;
                    best_sfo_d    = '0;
                    best_corr_d   = '0;
                    if (fft_mag_last) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        wr_addr_d = ADDR_ONE;
                        state_d   = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (fft_mag_valid) begin
                    wr_en_s = 1'b1;
                    if (fft_mag_last && (wr_addr_q == LAST_BIN)) begin
                        num_hyp_d = sweep_num_hyp;
                        step_d    = sweep_step;
                        hyp_d     = sweep_start;
                        k_d       = '0;
                        if (sweep_num_hyp == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RST;
                        end
                    end else if (fft_mag_last || (wr_addr_q == LAST_BIN)) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RST: begin
                rd_idx_s   = '0;
                play_cnt_d = '0;
                state_d    = S_PLAY;
            end
            S_PLAY: begin
                if (play_cnt_q == LAST_BIN) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    play_cnt_d = play_cnt_q + ADDR_ONE;
                end
            end
            S_WAIT: begin
                if (correlation_in_valid) begin
                    score_d     = correlation_in;
                    score_vld_d = 1'b1;
                    state_d     = S_CMP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    score_vld_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_CMP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            S_CMP: begin
                // Strict greater-than keeps the earliest index on ties.
                if (score_vld_q && ((k_q == '0) || (score_q > best_corr_q))) begin
                    best_index_d = k_q;
                    best_sfo_d   = hyp_q;
                    best_corr_d  = score_q;
                end else begin
                    best_index_d = best_index_q;
                end
                k_d   = k_q + HYP_ONE;
                hyp_d = hyp_q + step_q;
                if (k_q == (num_hyp_q - HYP_ONE)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= fft_mag_in;
        end
    end

    // State, datapath registers and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            wr_addr_q      <= '0;
            play_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            k_q            <= '0;
            num_hyp_q      <= '0;
            hyp_q          <= '0;
            step_q         <= '0;
            score_q        <= '0;
            score_vld_q    <= 1'b0;
            best_index_q   <= '0;
            best_sfo_q     <= '0;
            best_corr_q    <= '0;
            timeout_err_q  <= 1'b0;
            frame_err_q    <= 1'b0;
            result_valid_q <= 1'b0;
            corr_reset_q   <= 1'b0;
            corr_update_q  <= 1'b0;
            ready_q        <= 1'b1;
            busy_q         <= 1'b0;
            mag_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            play_cnt_q     <= play_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            k_q            <= k_d;
            num_hyp_q      <= num_hyp_d;
            hyp_q          <= hyp_d;
            step_q         <= step_d;
            score_q        <= score_d;
            score_vld_q    <= score_vld_d;
            best_index_q   <= best_index_d;
            best_sfo_q     <= best_sfo_d;
            best_corr_q    <= best_corr_d;
            timeout_err_q  <= timeout_err_d;
            frame_err_q    <= frame_err_d;
            result_valid_q <= (state_d == S_DONE);
            corr_reset_q   <= (state_d == S_RST);
            corr_update_q  <= (state_d == S_PLAY);
            ready_q        <= (state_d == S_IDLE) || (state_d == S_LOAD);
            busy_q         <= (state_d != S_IDLE);
            mag_out_q      <= (state_d == S_PLAY) ? mem_q[rd_idx_s] : '0;
        end
    end

    assign fft_mag_ready      = ready_q;
    assign sfo_int_part       = hyp_q[SFO_W-1:SFO_FRAC_WIDTH];
    assign sfo_frac_part      = hyp_q[SFO_FRAC_WIDTH-1:0];
    assign correlation_reset  = corr_reset_q;
    assign correlation_update = corr_update_q;
    assign fft_mag_out        = mag_out_q;
    assign best_index         = best_index_q;
    assign best_sfo           = best_sfo_q;
    assign best_corr          = best_corr_q;
    assign result_valid       = result_valid_q;
    assign busy               = busy_q;
    assign timeout_err        = timeout_err_q;
    assign frame_err          = frame_err_q;

endmodule

// File: tb/tb_sfo_sweep_controller.sv
// Directed bench for sfo_sweep_controller with a behavioural correlator model.
module tb_sfo_sweep_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] fft_mag_in = 16'd0;
    logic        fft_mag_valid = 1'b0;
    logic        fft_mag_last = 1'b0;
    logic        fft_mag_ready;
    logic [24:0] sweep_start = 25'd0;
    logic [24:0] sweep_step = 25'd0;
    logic [7:0]  sweep_num_hyp = 8'd0;
    logic [8:0]  sfo_int_part;
    logic [15:0] sfo_frac_part;
    logic        correlation_reset;
    logic        correlation_update;
    logic [15:0] fft_mag_out;
    logic [25:0] correlation_in = 26'd0;
    logic        correlation_in_valid = 1'b0;
    logic [7:0]  best_index;
    logic [24:0] best_sfo;
    logic [25:0] best_corr;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;
    logic        frame_err;

    always #5 clk = ~clk;

    sfo_sweep_controller dut (
        .clk(clk), .reset_n(reset_n),
        .fft_mag_in(fft_mag_in), .fft_mag_valid(fft_mag_valid), .fft_mag_last(fft_mag_last),
        .fft_mag_ready(fft_mag_ready),
        .sweep_start(sweep_start), .sweep_step(sweep_step), .sweep_num_hyp(sweep_num_hyp),
        .sfo_int_part(sfo_int_part), .sfo_frac_part(sfo_frac_part),
        .correlation_reset(correlation_reset), .correlation_update(correlation_update),
        .fft_mag_out(fft_mag_out),
        .correlation_in(correlation_in), .correlation_in_valid(correlation_in_valid),
        .best_index(best_index), .best_sfo(best_sfo), .best_corr(best_corr),
        .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err), .frame_err(frame_err)
    );

    int nchk = 0;
    int npass = 0;
    logic [15:0] gold [512];
    int          mode = 0;
    logic [25:0] score_tab [8];
    int          lat_tab [8];

    // correlator model state (observed on the falling edge)
    int          hidx = -1;
    int          pos = 0;
    int          lat_ctr = 0;
    int          rst_cyc [8];
    int          upd_cyc [8];
    int          upd_runs [8];
    int          gap_cyc [8];
    int          data_err = 0;
    int          hyp_err = 0;
    int          rv_cnt = 0;
    int          fe_cnt = 0;
    logic [24:0] cur_hyp = 25'd0;
    bit          prev_rst = 1'b0;
    bit          prev_upd = 1'b0;

    function automatic logic [25:0] peak_score(input logic [24:0] h);
        int p;
        int d;
        int s;
        p = int'(h[24:16]);
        d = (p > 32) ? (p - 32) : (32 - p);
        s = 1000 - 100 * d;
        if (s < 0) s = 0;
        return 26'(s);
    endfunction

    // Behavioural correlator: scores each replay and records per-hypothesis activity.
    always @(negedge clk) begin
        int h;
        if (!reset_n) begin
            correlation_in_valid = 1'b0;
            prev_rst = 1'b0;
            prev_upd = 1'b0;
        end else begin
            if (fft_mag_valid && fft_mag_ready && !busy) begin
                hidx = -1;
                data_err = 0; hyp_err = 0; rv_cnt = 0; fe_cnt = 0;
                for (int i = 0; i < 8; i++) begin
                    rst_cyc[i] = 0; upd_cyc[i] = 0; upd_runs[i] = 0; gap_cyc[i] = 0;
                end
            end
            if (result_valid) rv_cnt++;
            if (frame_err) fe_cnt++;
            if (correlation_reset) begin
                correlation_in_valid = 1'b0;
                lat_ctr = 0;
                if (!prev_rst) begin
                    hidx++;
                    cur_hyp = {sfo_int_part, sfo_frac_part};
                    pos = 0;
                end
            end
            h = (hidx < 0) ? 0 : ((hidx > 7) ? 7 : hidx);
            if (correlation_reset) begin
                rst_cyc[h]++;
            end else if (correlation_update) begin
                if (!prev_upd) upd_runs[h]++;
                upd_cyc[h]++;
                if (pos >= 512 || fft_mag_out !== gold[pos]) data_err++;
                if ({sfo_int_part, sfo_frac_part} !== cur_hyp) hyp_err++;
                pos++;
            end else if (busy && hidx >= 0) begin
                gap_cyc[h]++;
                if (upd_cyc[h] == 512 && !correlation_in_valid && lat_tab[h] >= 0) begin
                    if (lat_ctr == lat_tab[h]) begin
                        correlation_in_valid = 1'b1;
                        correlation_in = (mode == 0) ? peak_score(cur_hyp) : score_tab[h];
                    end
                    lat_ctr++;
                end
            end
            prev_rst = correlation_reset;
            prev_upd = correlation_update;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int nbeats, input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            if (i == 200) begin
                fft_mag_valid = 1'b0;
                fft_mag_last = 1'b0;
                cyc(2);
            end
            fft_mag_valid = 1'b1;
            fft_mag_in = gold[i];
            fft_mag_last = (i == last_at);
            cyc(1);
        end
        fft_mag_valid = 1'b0;
        fft_mag_last = 1'b0;
    endtask

    task automatic run_sweep(input logic [24:0] st, input logic [24:0] sp, input logic [7:0] n);
        sweep_start = st;
        sweep_step = sp;
        sweep_num_hyp = n;
        send_frame(512, 511);
    endtask

    task automatic wait_result(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
        cyc(4);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 8; i++) begin
            lat_tab[i] = 3;
            score_tab[i] = 26'd0;
        end
        for (int i = 0; i < 512; i++) gold[i] = ((i % 32) == 0) ? (16'hC000 + 16'(i)) : 16'((i * 3) & 255);

        // reset state
        cyc(2);
        chk("rst_ready", 64'(fft_mag_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result_valid), 64'd0);
        chk("rst_best_corr", 64'(best_corr), 64'd0);
        chk("rst_sfo", 64'({sfo_int_part, sfo_frac_part}), 64'd0);
        reset_n = 1'b1;
        cyc(2);

        // harmonic comb, hypotheses 30.0 .. 34.0, peak at 32.0
        mode = 0;
        run_sweep({9'd30, 16'd0}, {9'd1, 16'd0}, 8'd5);
        wait_result(4000, "main_done");
        chk("main_best_index", 64'(best_index), 64'd2);
        chk("main_best_sfo", 64'(best_sfo), 64'({9'd32, 16'd0}));
        chk("main_best_corr", 64'(best_corr), 64'd1000);
        chk("main_rv_pulses", 64'(rv_cnt), 64'd1);
        chk("main_hyp_count", 64'(hidx), 64'd4);
        for (int k = 0; k < 5; k++) begin
            chk("main_rst_cycles", 64'(rst_cyc[k]), 64'd1);
            chk("main_upd_cycles", 64'(upd_cyc[k]), 64'd512);
            chk("main_upd_runs", 64'(upd_runs[k]), 64'd1);
        end
        chk("main_data", 64'(data_err), 64'd0);
        chk("main_hyp_stable", 64'(hyp_err), 64'd0);
        chk("main_wait_gap", 64'(gap_cyc[0]), 64'd5);
        chk("main_timeout", 64'(timeout_err), 64'd0);
        chk("main_idle_busy", 64'(busy), 64'd0);

        // tie between k=1 and k=2, fractional hypotheses
        for (int i = 0; i < 512; i++) gold[i] = 16'(i * 7 + 5);
        mode = 1;
        score_tab[0] = 26'h80; score_tab[1] = 26'h100; score_tab[2] = 26'h100; score_tab[3] = 26'h40;
        run_sweep({9'd5, 16'h8000}, {9'd0, 16'h4000}, 8'd4);
        wait_result(4000, "tie_done");
        chk("tie_best_index", 64'(best_index), 64'd1);
        chk("tie_best_sfo", 64'(best_sfo), 64'({9'd5, 16'hC000}));
        chk("tie_best_corr", 64'(best_corr), 64'h100);
        chk("tie_data", 64'(data_err), 64'd0);

        // k=1 of 3 never scores; hypothesis wraps around the 25-bit range
        score_tab[0] = 26'h10; score_tab[1] = 26'h500; score_tab[2] = 26'h20;
        lat_tab[1] = -1;
        run_sweep({9'h1FF, 16'hF000}, {9'd0, 16'h2000}, 8'd3);
        wait_result(4000, "to_done");
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_wait_gap", 64'(gap_cyc[1]), 64'd65);
        chk("to_best_index", 64'(best_index), 64'd2);
        chk("to_best_sfo", 64'(best_sfo), 64'({9'd0, 16'h3000}));
        chk("to_best_corr", 64'(best_corr), 64'h20);
        chk("to_hyp_count", 64'(hidx), 64'd2);
        cyc(10);
        chk("to_sticky", 64'(timeout_err), 64'd1);
        lat_tab[1] = 3;

        // early last on bin 100
        send_frame(101, 100);
        cyc(2);
        chk("fe_pulse", 64'(fe_cnt), 64'd1);
        chk("fe_ready", 64'(fft_mag_ready), 64'd1);
        chk("fe_busy", 64'(busy), 64'd0);
        chk("fe_no_corr_reset", 64'(hidx), -64'sd1);
        chk("fe_timeout_cleared", 64'(timeout_err), 64'd0);
        chk("fe_best_cleared", 64'(best_corr), 64'd0);

        // bin 511 without last
        send_frame(512, -1);
        cyc(2);
        chk("fe_nolast_pulse", 64'(fe_cnt), 64'd1);
        chk("fe_nolast_busy", 64'(busy), 64'd0);

        // zero-hypothesis sweep
        run_sweep({9'd7, 16'd0}, {9'd1, 16'd0}, 8'd0);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1'b1;
        end
        chk("zero_done", 64'(seen), 64'd1);
        chk("zero_best_corr", 64'(best_corr), 64'd0);
        chk("zero_best_sfo", 64'(best_sfo), 64'd0);
        cyc(3);
        chk("zero_no_corr_reset", 64'(hidx), -64'sd1);
        chk("zero_rv_pulses", 64'(rv_cnt), 64'd1);

        // asynchronous reset in the middle of playback
        mode = 0;
        for (int i = 0; i < 512; i++) gold[i] = 16'(i ^ 16'h5A5A);
        run_sweep({9'd31, 16'd0}, {9'd1, 16'd0}, 8'd2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (correlation_update === 1'b1) seen = 1'b1;
        end
        chk("arst_play_seen", 64'(seen), 64'd1);
        cyc(100);
        reset_n = 1'b0;
        #1;
        chk("arst_update", 64'(correlation_update), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(fft_mag_ready), 64'd1);
        chk("arst_mag_out", 64'(fft_mag_out), 64'd0);
        chk("arst_sfo", 64'({sfo_int_part, sfo_frac_part}), 64'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        chk("arst_post_ready", 64'(fft_mag_ready), 64'd1);
        chk("arst_post_busy", 64'(busy), 64'd0);
        run_sweep({9'd31, 16'd0}, {9'd1, 16'd0}, 8'd2);
        wait_result(4000, "arst_done");
        chk("arst_best_index", 64'(best_index), 64'd1);
        chk("arst_best_sfo", 64'(best_sfo), 64'({9'd32, 16'd0}));
        chk("arst_hyp_count", 64'(hidx), 64'd1);
        chk("arst_data", 64'(data_err), 64'd0);
        chk("arst_upd_cycles", 64'(upd_cyc[1]), 64'd512);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
